// File: rtl/ysyx_25040111_trap_seq.sv
// ysyx_25040111_trap_seq
// Multi-cycle trap sequencer between EXU and the CSR file. It handles the SYSTEM
// ops ecall (trap entry), mret (trap return) and ebreak (halt). It drives the
// single shared CSR port with at most one access per cycle, and it pulses a
// redirect to IFU at the end of ecall and mret.
//
// Optional feature macro: YSYX_25040111_TRAP_MSTATUS_EN
//   Defined   : mstatus is read and rewritten on both ecall and mret
//               (MIE/MPIE stack, MPP forced to M-mode).
//   Undefined : mstatus is never accessed.
module ysyx_25040111_trap_seq #(
  parameter logic [31:0] ECALL_CAUSE = 32'd11,
  parameter logic [31:0] MTVEC_MASK  = 32'hFFFF_FFFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_pc,
  output logic [11:0] csr_addr,
  output logic        csr_wen,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic        halt
);

  localparam logic [1:0] OP_NONE   = 2'b00;
  localparam logic [1:0] OP_ECALL  = 2'b01;
  localparam logic [1:0] OP_MRET   = 2'b10;
  localparam logic [1:0] OP_EBREAK = 2'b11;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_EPC_WR   = 4'd1;
  localparam logic [3:0] S_CAUSE_WR = 4'd2;
  localparam logic [3:0] S_VEC_RD   = 4'd3;
  localparam logic [3:0] S_EPC_RD   = 4'd4;
  localparam logic [3:0] S_REDIR    = 4'd5;
  localparam logic [3:0] S_HALT     = 4'd6;
`ifdef YSYX_25040111_TRAP_MSTATUS_EN
  localparam logic [3:0] S_MST_RD   = 4'd7;
  localparam logic [3:0] S_MST_WR   = 4'd8;
`endif

  logic [3:0]  state;
  logic [3:0]  state_d;
  logic [31:0] pc_q;
  logic [31:0] tgt_q;
  logic        accept;

`ifdef YSYX_25040111_TRAP_MSTATUS_EN
  logic        is_mret_q;   // selects the mstatus update rule and the exit path of MST_WR
  logic [31:0] mst_q;       // mstatus value captured in MST_RD
  logic [31:0] mst_new;
`endif

  assign accept = req_valid & req_ready;

`ifdef YSYX_25040111_TRAP_MSTATUS_EN
  // New mstatus value: ecall pushes MIE into MPIE, mret pops it back; MPP stays M-mode.
  always_comb begin
    mst_new        = mst_q;
    mst_new[12:11] = 2'b11;
    if (is_mret_q) begin
      mst_new[3] = mst_q[7];
      mst_new[7] = 1'b1;
    end else begin
      mst_new[7] = mst_q[3];
      mst_new[3] = 1'b0;
    end
  end
`endif

  // Next-state logic for the trap sequence.
  always_comb begin
    // NOTE: default assignment first so every path assigns state_d and no latch is inferred.
    state_d = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          case (req_op)
            OP_ECALL:  state_d = S_EPC_WR;
`ifdef YSYX_25040111_TRAP_MSTATUS_EN
            OP_MRET:   state_d = S_MST_RD;
`else
            OP_MRET:   state_d = S_EPC_RD;
`endif
            OP_EBREAK: state_d = S_HALT;
            OP_NONE:   state_d = S_IDLE;   // accepted and dropped
            default:   state_d = S_IDLE;
          endcase
        end
      end
      S_EPC_WR:   state_d = S_CAUSE_WR;
`ifdef YSYX_25040111_TRAP_MSTATUS_EN
      S_CAUSE_WR: state_d = S_MST_RD;
      S_MST_RD:   state_d = S_MST_WR;
      S_MST_WR:   state_d = is_mret_q ? S_EPC_RD : S_VEC_RD;
`else
      S_CAUSE_WR: state_d = S_VEC_RD;
`endif
      S_VEC_RD:   state_d = S_REDIR;
      S_EPC_RD:   state_d = S_REDIR;
      S_REDIR:    state_d = S_IDLE;
      S_HALT:     state_d = S_HALT;    // sticky until reset
      default:    state_d = S_IDLE;
    endcase
  end

  // Per-state CSR port and status outputs; unused cycles drive zeros on the CSR port.
  always_comb begin
    csr_addr       = 12'h000;
    csr_wen        = 1'b0;
    csr_wdata      = 32'h0;
    redirect_valid = 1'b0;
    case (state)
      S_EPC_WR: begin
        csr_addr  = CSR_MEPC;
        csr_wen   = 1'b1;
        csr_wdata = pc_q;
      end
      S_CAUSE_WR: begin
        csr_addr  = CSR_MCAUSE;
        csr_wen   = 1'b1;
        csr_wdata = ECALL_CAUSE;
      end
`ifdef YSYX_25040111_TRAP_MSTATUS_EN
      S_MST_RD: csr_addr = CSR_MSTATUS;
      S_MST_WR: begin
        csr_addr  = CSR_MSTATUS;
        csr_wen   = 1'b1;
        csr_wdata = mst_new;
      end
`endif
      S_VEC_RD: csr_addr = CSR_MTVEC;
      S_EPC_RD: csr_addr = CSR_MEPC;
      S_REDIR:  redirect_valid = 1'b1;
      default: ;
    endcase
  end

  assign req_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE) && (state != S_HALT);
  assign halt        = (state == S_HALT);
  assign redirect_pc = tgt_q;

  // State, latched request PC and redirect target.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state <= S_IDLE;
      pc_q  <= 32'h0;
      tgt_q <= 32'h0;
    end else begin
      state <= state_d;
      if (accept)
        pc_q <= req_pc;
      if (state == S_VEC_RD)
        tgt_q <= csr_rdata & MTVEC_MASK;
      else if (state == S_EPC_RD)
        tgt_q <= csr_rdata;
    end
  end

`ifdef YSYX_25040111_TRAP_MSTATUS_EN
  // Remember which op is running and capture mstatus for the read-modify-write.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_mret_q <= 1'b0;
      mst_q     <= 32'h0;
    end else begin
      if (accept)
        is_mret_q <= (req_op == OP_MRET);
      if (state == S_MST_RD)
        mst_q <= csr_rdata;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_25040111_trap_seq.sv
// Testbench for ysyx_25040111_trap_seq. It contains a small CSR file, and a
// transaction model that expands each accepted op into the CSR accesses and the
// redirect that the op must produce cycle by cycle. A negedge monitor compares
// every output against that model. Directed scenarios add literal checks on
// redirect targets, latencies and final CSR contents.
module tb_ysyx_25040111_trap_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_pc;
  logic [11:0] csr_addr;
  logic        csr_wen;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;
  logic        halt;

  always #5 clk = ~clk;

  ysyx_25040111_trap_seq dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_pc(req_pc),
    .csr_addr(csr_addr), .csr_wen(csr_wen), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy), .halt(halt)
  );

`ifdef YSYX_25040111_TRAP_MSTATUS_EN
  localparam int LAT_E = 6;
  localparam int LAT_M = 4;
`else
  localparam int LAT_E = 4;
  localparam int LAT_M = 2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- CSR file ----------------
  logic [31:0] mepc_r, mcause_r, mtvec_r, mstatus_r;

  always_comb begin
    case (csr_addr)
      12'h300: csr_rdata = mstatus_r;
      12'h305: csr_rdata = mtvec_r;
      12'h341: csr_rdata = mepc_r;
      12'h342: csr_rdata = mcause_r;
      default: csr_rdata = 32'hDEAD_BEEF;
    endcase
  end

  always @(posedge clk) begin
    if (csr_wen) begin
      case (csr_addr)
        12'h300: mstatus_r <= csr_wdata;
        12'h305: mtvec_r   <= csr_wdata;
        12'h341: mepc_r    <= csr_wdata;
        12'h342: mcause_r  <= csr_wdata;
        default: ;
      endcase
    end
  end

  // ---------------- transaction model ----------------
  typedef struct packed {
    logic [11:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic        redir;
    logic [31:0] tgt;
  } step_t;

  step_t       exp_q[$];
  logic        halted_m = 1'b0;
  logic [31:0] tgt_m    = 32'h0;
  logic        mon_en   = 1'b0;
  int          cyc      = 0;
  int          acc_cyc  = 0;
  int          acc_cnt  = 0;
  int          redir_cnt = 0;
  int          last_lat = 0;
  int          last_redir_cyc = 0;
  int          last_acc_gap_base = 0;
  logic [31:0] last_rpc = 32'h0;

  function automatic step_t mk(input logic [11:0] a, input logic w, input logic [31:0] d,
                               input logic r, input logic [31:0] t);
    step_t s;
    s.addr = a; s.wen = w; s.wdata = d; s.redir = r; s.tgt = t;
    return s;
  endfunction

  // Expand an accepted op into its expected per-cycle activity.
  task automatic model_accept(input logic [1:0] op, input logic [31:0] pc);
`ifdef YSYX_25040111_TRAP_MSTATUS_EN
    logic [31:0] s = mstatus_r;
    logic [31:0] ms_e = (s & ~32'h1888) | ((s & 32'h8) << 4) | 32'h1800;
    logic [31:0] ms_m = (s & ~32'h1888) | ((s & 32'h80) >> 4) | 32'h80 | 32'h1800;
`endif
    case (op)
      2'b01: begin
        exp_q.push_back(mk(12'h341, 1'b1, pc, 1'b0, 32'h0));
        exp_q.push_back(mk(12'h342, 1'b1, 32'd11, 1'b0, 32'h0));
`ifdef YSYX_25040111_TRAP_MSTATUS_EN
        exp_q.push_back(mk(12'h300, 1'b0, 32'h0, 1'b0, 32'h0));
        exp_q.push_back(mk(12'h300, 1'b1, ms_e, 1'b0, 32'h0));
`endif
        exp_q.push_back(mk(12'h305, 1'b0, 32'h0, 1'b0, 32'h0));
        exp_q.push_back(mk(12'h000, 1'b0, 32'h0, 1'b1, mtvec_r & 32'hFFFF_FFFC));
      end
      2'b10: begin
`ifdef YSYX_25040111_TRAP_MSTATUS_EN
        exp_q.push_back(mk(12'h300, 1'b0, 32'h0, 1'b0, 32'h0));
        exp_q.push_back(mk(12'h300, 1'b1, ms_m, 1'b0, 32'h0));
`endif
        exp_q.push_back(mk(12'h341, 1'b0, 32'h0, 1'b0, 32'h0));
        exp_q.push_back(mk(12'h000, 1'b0, 32'h0, 1'b1, mepc_r));
      end
      2'b11: halted_m = 1'b1;
      default: ;
    endcase
  endtask

  // Per-cycle compare: outputs are stable mid-cycle, inputs change after posedge.
  always @(negedge clk) begin
    if (mon_en) begin
      step_t s;
      logic  in_seq;
      cyc++;
      in_seq = (exp_q.size() > 0);
      s = in_seq ? exp_q.pop_front() : mk(12'h000, 1'b0, 32'h0, 1'b0, 32'h0);
      if (s.redir) tgt_m = s.tgt;
      check("csr_addr",       {20'h0, csr_addr}, {20'h0, s.addr});
      check("csr_wen",        {31'h0, csr_wen}, {31'h0, s.wen});
      check("csr_wdata",      csr_wdata, s.wdata);
      check("redirect_valid", {31'h0, redirect_valid}, {31'h0, s.redir});
      check("redirect_pc",    redirect_pc, tgt_m);
      check("busy",           {31'h0, busy}, {31'h0, in_seq});
      check("halt",           {31'h0, halt}, {31'h0, halted_m});
      check("req_ready",      {31'h0, req_ready}, {31'h0, !in_seq && !halted_m});
      if (redirect_valid) begin
        last_lat       = cyc - acc_cyc;
        last_rpc       = redirect_pc;
        last_redir_cyc = cyc;
        redir_cnt++;
      end
      if (rst) begin
        exp_q.delete();
        halted_m = 1'b0;
        tgt_m    = 32'h0;
      end else if (req_valid && !in_seq && !halted_m) begin
        acc_cyc = cyc;
        acc_cnt++;
        model_accept(req_op, req_pc);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic issue(input logic [1:0] op, input logic [31:0] pc);
    @(posedge clk); #2;
    req_valid = 1'b1; req_op = op; req_pc = pc;
    @(posedge clk); #2;
    req_valid = 1'b0; req_op = 2'b00;
  endtask

  task automatic wait_redir(input int target_cnt, input string name);
    int n = 0;
    while (redir_cnt < target_cnt && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (redir_cnt < target_cnt) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: redirect timeout, got %0d pulses, expected %0d", name, redir_cnt, target_cnt);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    int base;
    rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_pc = 32'h0;
    mepc_r = 32'h0; mcause_r = 32'h0; mtvec_r = 32'h8000_0103; mstatus_r = 32'h0000_0008;
    @(posedge clk); #2;
    mon_en = 1'b1;
    @(posedge clk); #3;
    // Reset state
    check("rst_ready",  {31'h0, req_ready}, 32'h1);
    check("rst_busy",   {31'h0, busy}, 32'h0);
    check("rst_halt",   {31'h0, halt}, 32'h0);
    check("rst_redir",  {31'h0, redirect_valid}, 32'h0);
    check("rst_rpc",    redirect_pc, 32'h0);
    check("rst_addr",   {20'h0, csr_addr}, 32'h0);
    #2 rst = 1'b0;

    // 1: ecall entry
    issue(2'b01, 32'h8000_0010);
    wait_redir(1, "ecall");
    #3;
    check("ecall_rpc",    last_rpc, 32'h8000_0100);
    check("ecall_lat",    last_lat, LAT_E);
    check("ecall_mepc",   mepc_r, 32'h8000_0010);
    check("ecall_mcause", mcause_r, 32'd11);
`ifdef YSYX_25040111_TRAP_MSTATUS_EN
    check("ecall_mstatus", mstatus_r, 32'h0000_1880);
`else
    check("ecall_mstatus", mstatus_r, 32'h0000_0008);
`endif

    // 2: mret return
    mepc_r = 32'h8000_0014;
    issue(2'b10, 32'h8000_0020);
    wait_redir(2, "mret");
    #3;
    check("mret_rpc",  last_rpc, 32'h8000_0014);
    check("mret_lat",  last_lat, LAT_M);
    check("mret_mepc", mepc_r, 32'h8000_0014);
`ifdef YSYX_25040111_TRAP_MSTATUS_EN
    check("mret_mstatus", mstatus_r, 32'h0000_1888);
`else
    check("mret_mstatus", mstatus_r, 32'h0000_0008);
`endif

    // 4: reset while in CAUSE_WR
    idle(2);
    issue(2'b01, 32'h8000_0040);      // returns during EPC_WR
    base = redir_cnt;
    @(posedge clk); #2 rst = 1'b1;    // CAUSE_WR cycle
    @(posedge clk); #2 rst = 1'b0;
    #1;
    check("rstmid_idle", {31'h0, req_ready}, 32'h1);
    idle(12);
    check("rstmid_noredir", redir_cnt, base);
    check("rstmid_mepc", mepc_r, 32'h8000_0040);

    // 5: ecall then mret with req_valid held; then op00 held
    base = acc_cnt;
    @(posedge clk); #2;
    req_valid = 1'b1; req_op = 2'b01; req_pc = 32'h8000_0080;
    @(posedge clk); #2;
    req_op = 2'b10; req_pc = 32'h8000_0090;
    begin
      int n = 0;
      while (acc_cnt < base + 2 && n < 40) begin
        @(posedge clk);
        n++;
      end
      #2;
    end
    check("b2b_accepts", acc_cnt, base + 2);
    check("b2b_gap", acc_cyc, last_redir_cyc + 1);
    check("b2b_ecall_rpc", last_rpc, 32'h8000_0100);
    req_op = 2'b00;
    base = redir_cnt;
    wait_redir(base + 1, "b2b_mret");
    #3;
    check("b2b_mret_rpc", last_rpc, 32'h8000_0080);
    base = redir_cnt;
    idle(10);
    check("op00_noredir", redir_cnt, base);
    #2 req_valid = 1'b0;

    // 3: ebreak halts until reset, other requests ignored
    issue(2'b11, 32'h8000_00A0);
    idle(50);
    @(posedge clk); #2;
    req_valid = 1'b1; req_op = 2'b01; req_pc = 32'h8000_00B0;
    idle(50);
    #3;
    check("halt_sticky", {31'h0, halt}, 32'h1);
    check("halt_ready",  {31'h0, req_ready}, 32'h0);
    check("halt_mepc",   mepc_r, 32'h8000_0080);
    req_valid = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    #1;
    check("halt_rst_halt",  {31'h0, halt}, 32'h0);
    check("halt_rst_ready", {31'h0, req_ready}, 32'h1);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
